// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge_if
// Brief    : Command/response handshake and APB4 initiator bundle for the
//            APB master bridge.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_master_bridge_if;
    // command channel
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic [3:0]  cmd_strb_i;
    // response channel
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    // APB4 initiator
    logic [31:0] paddr_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic        pready_i;
    logic [31:0] prdata_i;
    logic        pslverr_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        input  rsp_ready_i,
        output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
        input  pready_i, prdata_i, pslverr_i
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        output rsp_ready_i,
        input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
        output pready_i, prdata_i, pslverr_i
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Brief    : Single-outstanding command/response to APB4 initiator bridge
//            with misalignment rejection and ACCESS-phase timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input wire logic            pclk_i,
    input wire logic            presetn_i,
    apb_master_bridge_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Counter value seen during the final permitted ACCESS cycle
    localparam logic [15:0] c_last_access = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_access_cnt;
    logic [31:0] r_paddr;
    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [31:0] r_pwdata;
    logic [3:0]  r_pstrb;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_rsp_timeout;

    logic        w_accept;
    logic        w_misaligned;

    assign w_accept     = bus.cmd_valid_i && (r_state == ST_IDLE);
    assign w_misaligned = (bus.cmd_addr_i[1:0] != 2'b00);

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            r_state       <= ST_IDLE;
            r_access_cnt  <= '0;
            r_paddr       <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_misaligned) begin
                            // Rejected without touching the APB bus
                            r_rsp_valid   <= 1'b1;
                            r_rsp_rdata   <= '0;
                            r_rsp_err     <= 1'b1;
                            r_rsp_timeout <= 1'b0;
                            r_state       <= ST_RESP;
                        end else begin
                            r_paddr      <= bus.cmd_addr_i;
                            r_pwrite     <= bus.cmd_write_i;
                            r_pwdata     <= bus.cmd_write_i ? bus.cmd_wdata_i : 32'h0;
                            r_pstrb      <= bus.cmd_write_i ? bus.cmd_strb_i  : 4'h0;
                            r_psel       <= 1'b1;
                            r_penable    <= 1'b0;
                            r_access_cnt <= '0;
                            r_state      <= ST_SETUP;
                        end
                    end
                end

                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    // A ready slave wins over a timeout on the same cycle
                    if (bus.pready_i) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_pwrite ? 32'h0 : bus.prdata_i;
                        r_rsp_err     <= bus.pslverr_i;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= ST_RESP;
                    end else if (r_access_cnt >= c_last_access) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= ST_RESP;
                    end else begin
                        r_access_cnt <= r_access_cnt + 16'd1;
                    end
                end

                ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready_o   = (r_state == ST_IDLE);
    assign bus.paddr_o       = r_paddr;
    assign bus.psel_o        = r_psel;
    assign bus.penable_o     = r_penable;
    assign bus.pwrite_o      = r_pwrite;
    assign bus.pwdata_o      = r_pwdata;
    assign bus.pstrb_o       = r_pstrb;
    assign bus.rsp_valid_o   = r_rsp_valid;
    assign bus.rsp_rdata_o   = r_rsp_rdata;
    assign bus.rsp_err_o     = r_rsp_err;
    assign bus.rsp_timeout_o = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Brief    : Self-checking bench; transaction timeline model plus directed
//            literal checks and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

    localparam int T = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    apb_master_bridge_if bus ();

    apb_master_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .pclk_i    (clk),
        .presetn_i (rst_n),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Expected per-cycle values, set by the stimulus from the transaction timeline
    bit          chk_en = 1'b0;
    bit          e_cr, e_ps, e_pe, e_rv;
    logic [31:0] m_paddr = '0, m_pwdata = '0, m_rdata = '0;
    logic        m_pwrite = 1'b0, m_err = 1'b0, m_tmo = 1'b0;
    logic [3:0]  m_pstrb = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_exp(input bit cr, input bit ps, input bit pe, input bit rv);
        e_cr = cr; e_ps = ps; e_pe = pe; e_rv = rv;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd_ready", bus.cmd_ready_o, e_cr);
            check("psel",      bus.psel_o,      e_ps);
            check("penable",   bus.penable_o,   e_pe);
            check("rsp_valid", bus.rsp_valid_o, e_rv);
            check("paddr",     bus.paddr_o,     m_paddr);
            check("pwrite",    bus.pwrite_o,    m_pwrite);
            check("pwdata",    bus.pwdata_o,    m_pwdata);
            check("pstrb",     bus.pstrb_o,     m_pstrb);
            if (e_rv) begin
                check("rsp_rdata",   bus.rsp_rdata_o,   m_rdata);
                check("rsp_err",     bus.rsp_err_o,     m_err);
                check("rsp_timeout", bus.rsp_timeout_o, m_tmo);
            end
        end
    end

    // Observation of the most recent transaction for literal checks
    int          cyc = 0;
    int          acc_cyc = 0, rsp_cyc = -1, psel_cnt = 0, pen_cnt = 0;
    logic [31:0] cap_rdata;
    logic        cap_err, cap_tmo, cap_pwrite;
    logic [3:0]  cap_pstrb;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && bus.cmd_valid_i && bus.cmd_ready_o) begin
            acc_cyc = cyc; rsp_cyc = -1; psel_cnt = 0; pen_cnt = 0;
        end else begin
            if (bus.psel_o) psel_cnt++;
            if (bus.penable_o) begin
                pen_cnt++; cap_pwrite = bus.pwrite_o; cap_pstrb = bus.pstrb_o;
            end
            if (bus.rsp_valid_o && rsp_cyc < 0) begin
                rsp_cyc = cyc; cap_rdata = bus.rsp_rdata_o;
                cap_err = bus.rsp_err_o; cap_tmo = bus.rsp_timeout_o;
            end
        end
    end

    task automatic cmd_noise();
        bus.cmd_valid_i = 1'($urandom);
        bus.cmd_write_i = 1'($urandom);
        bus.cmd_addr_i  = $urandom;
        bus.cmd_wdata_i = $urandom;
        bus.cmd_strb_i  = 4'($urandom);
    endtask

    task automatic apb_noise();
        bus.pready_i  = 1'($urandom);
        bus.prdata_i  = $urandom;
        bus.pslverr_i = 1'($urandom);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            bus.cmd_valid_i = 1'b0; bus.rsp_ready_i = 1'b0;
            apb_noise(); set_exp(1, 0, 0, 0); tick();
        end
    endtask

    // One command from acceptance to response handshake; waits = low-pready
    // ACCESS cycles before the ready one, rdly = cycles rsp_ready stays low.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input int waits, input int rdly,
                           input logic [31:0] rd, input bit serr);
        bit mis, tmo;
        int nacc;
        mis  = (addr[1:0] != 2'b00);
        tmo  = !mis && (waits >= T);
        nacc = tmo ? T : waits + 1;
        bus.cmd_valid_i = 1'b1; bus.cmd_write_i = wr; bus.cmd_addr_i = addr;
        bus.cmd_wdata_i = wd;   bus.cmd_strb_i = st;  bus.rsp_ready_i = 1'b0;
        apb_noise(); set_exp(1, 0, 0, 0);
        tick();
        if (!mis) begin
            m_paddr = addr; m_pwrite = wr;
            m_pwdata = wr ? wd : 32'h0; m_pstrb = wr ? st : 4'h0;
            cmd_noise(); apb_noise(); set_exp(0, 1, 0, 0);
            tick();
            for (int i = 1; i <= nacc; i++) begin
                cmd_noise(); set_exp(0, 1, 1, 0);
                if (!tmo && i == nacc) begin
                    bus.pready_i = 1'b1; bus.prdata_i = rd; bus.pslverr_i = serr;
                end else begin
                    bus.pready_i = 1'b0; bus.prdata_i = $urandom; bus.pslverr_i = 1'($urandom);
                end
                tick();
            end
        end
        m_rdata = (mis || tmo || wr) ? 32'h0 : rd;
        m_err   = (mis || tmo) ? 1'b1 : serr;
        m_tmo   = tmo;
        for (int j = 0; j <= rdly; j++) begin
            cmd_noise(); apb_noise(); set_exp(0, 0, 0, 1);
            bus.rsp_ready_i = (j == rdly);
            tick();
        end
        bus.cmd_valid_i = 1'b0; bus.rsp_ready_i = 1'b0;
        set_exp(1, 0, 0, 0);
    endtask

    task automatic reset_mid_access();
        bus.cmd_valid_i = 1'b1; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = 32'h10;
        bus.cmd_wdata_i = 32'h0; bus.cmd_strb_i = 4'h0; bus.pready_i = 1'b0;
        set_exp(1, 0, 0, 0);
        tick();
        m_paddr = 32'h10; m_pwrite = 1'b0; m_pwdata = 32'h0; m_pstrb = 4'h0;
        bus.cmd_valid_i = 1'b0; set_exp(0, 1, 0, 0);
        tick();
        set_exp(0, 1, 1, 0);
        tick();
        set_exp(0, 1, 1, 0);
        #2;
        // Asynchronous assertion well before the next edge
        rst_n = 1'b0;
        m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_pstrb = '0;
        set_exp(1, 0, 0, 0);
        bus.cmd_valid_i = 1'b1; bus.cmd_addr_i = 32'h20;
        tick();
        @(negedge clk); #1;
        rst_n = 1'b1; bus.cmd_valid_i = 1'b0;
        tick();
        idle(3);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid_i = 1'b1; bus.cmd_write_i = 1'b1; bus.cmd_addr_i = 32'h40;
        bus.cmd_wdata_i = 32'h1234; bus.cmd_strb_i = 4'hF; bus.rsp_ready_i = 1'b0;
        bus.pready_i = 1'b0; bus.prdata_i = '0; bus.pslverr_i = 1'b0;
        set_exp(1, 0, 0, 0);
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1; bus.cmd_valid_i = 1'b0;
        tick();
        idle(2);

        // Zero-wait write
        run_txn(1'b1, 32'h0, 32'h1, 4'hF, 0, 0, 32'h0, 1'b0);
        check("wr_rsp_latency", 32'(rsp_cyc - acc_cyc), 32'd3);
        check("wr_psel_cycles", 32'(psel_cnt), 32'd2);
        check("wr_penable_cycles", 32'(pen_cnt), 32'd1);
        check("wr_pwrite", cap_pwrite, 1'b1);
        check("wr_rsp_err", cap_err, 1'b0);
        check("wr_rsp_rdata", cap_rdata, 32'h0);
        check("wr_cmd_ready_next", bus.cmd_ready_o, 1'b1);
        idle(1);

        // Read with three wait states: ready lands on the limit cycle
        run_txn(1'b0, 32'h4, 32'hFFFF_FFFF, 4'hF, 3, 1, 32'hDEAD_BEEF, 1'b0);
        check("rd_penable_cycles", 32'(pen_cnt), 32'd4);
        check("rd_pstrb", cap_pstrb, 4'h0);
        check("rd_rdata", cap_rdata, 32'hDEAD_BEEF);
        check("rd_err", cap_err, 1'b0);
        idle(1);

        // Slave error
        run_txn(1'b0, 32'h8, 32'h0, 4'h0, 1, 0, 32'hCAFE_0001, 1'b1);
        check("slverr_err", cap_err, 1'b1);
        check("slverr_tmo", cap_tmo, 1'b0);
        check("slverr_rdata", cap_rdata, 32'hCAFE_0001);

        // Timeout
        run_txn(1'b0, 32'hC, 32'h0, 4'h0, 20, 0, 32'h0, 1'b0);
        check("tmo_penable_cycles", 32'(pen_cnt), 32'd4);
        check("tmo_err", cap_err, 1'b1);
        check("tmo_flag", cap_tmo, 1'b1);
        check("tmo_rdata", cap_rdata, 32'h0);

        // Misaligned with held-off response
        run_txn(1'b1, 32'h2, 32'hAAAA_5555, 4'hF, 0, 5, 32'h0, 1'b0);
        check("mis_psel_cycles", 32'(psel_cnt), 32'd0);
        check("mis_rsp_latency", 32'(rsp_cyc - acc_cyc), 32'd1);
        check("mis_err", cap_err, 1'b1);
        check("mis_tmo", cap_tmo, 1'b0);
        idle(1);

        reset_mid_access();
        run_txn(1'b0, 32'h24, 32'h0, 4'h0, 0, 0, 32'h0BAD_F00D, 1'b0);
        check("post_reset_rdata", cap_rdata, 32'h0BAD_F00D);
        check("post_reset_latency", 32'(rsp_cyc - acc_cyc), 32'd3);

        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            run_txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 3)), $urandom, 1'($urandom));
            idle(int'($urandom_range(0, 2)));
        end

        idle(2);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
